// File: rtl/router_out_port.sv
// rtl/router_out_port.sv - egress controller draining a router FIFO onto a valid/ready byte stream
// Optional PARITY_CHK_EN: per-packet XOR check reported on parity_err.
module router_out_port #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 30,
  parameter int TO_W    = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              soft_reset_out,
  input  logic              dst_ready,
  output logic              dst_valid,
  output logic [DATA_W-1:0] dst_data,
  output logic              dst_sop,
  output logic              dst_eop,
  output logic              parity_err,
  output logic              busy
);

  typedef enum logic [1:0] {EXP_HDR, PAYLOAD, PARITY} parse_t;

  parse_t            state_q, state_d;
  logic [5:0]        rem_q, rem_d;
  logic [DATA_W-1:0] data0_q, data1_q;
  logic              sop0_q, sop1_q, eop0_q, eop1_q;
  logic [1:0]        occ_q;
  logic              inflight_q;
  logic [TO_W-1:0]   stall_q;
  logic              pop, wr_ent1, in_sop, in_eop;

  assign dst_valid      = (occ_q != 2'd0);
  assign pop            = dst_valid & dst_ready;
  assign dst_data       = data0_q;
  assign dst_sop        = sop0_q & dst_valid;
  assign dst_eop        = eop0_q & dst_valid;
  assign soft_reset_out = (stall_q == TO_W'(TIMEOUT));

  // Count bytes already owed to the buffer so a 2-entry buffer sustains 1 byte/cycle.
  assign fifo_rd_en = resetn & ~fifo_empty & ~soft_reset_out &
                      (({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

  assign wr_ent1 = ((occ_q == 2'd2) && pop) || ((occ_q == 2'd1) && !pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= EXP_HDR;
      rem_q   <= '0;
    end else if (soft_reset_out) begin
      state_q <= EXP_HDR;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    in_sop  = 1'b0;
    in_eop  = 1'b0;
    if (inflight_q) begin
      unique case (state_q)
        EXP_HDR: begin
          in_sop  = 1'b1;
          rem_d   = fifo_data[DATA_W-1:2];
          state_d = (fifo_data[DATA_W-1:2] == 6'd0) ? PARITY : PAYLOAD;
        end
        PAYLOAD: begin
          rem_d = rem_q - 6'd1;
          if (rem_q == 6'd1) state_d = PARITY;
        end
        PARITY: begin
          in_eop  = 1'b1;
          state_d = EXP_HDR;
        end
        default: state_d = EXP_HDR;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn || soft_reset_out) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      data0_q    <= '0;
      data1_q    <= '0;
      sop0_q     <= 1'b0;
      sop1_q     <= 1'b0;
      eop0_q     <= 1'b0;
      eop1_q     <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      occ_q      <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
      if (pop) begin
        data0_q <= data1_q;
        sop0_q  <= sop1_q;
        eop0_q  <= eop1_q;
      end
      if (inflight_q) begin
        if (wr_ent1) {data1_q, sop1_q, eop1_q} <= {fifo_data, in_sop, in_eop};
        else         {data0_q, sop0_q, eop0_q} <= {fifo_data, in_sop, in_eop};
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn || soft_reset_out) begin
      busy    <= 1'b0;
      stall_q <= '0;
    end else begin
      if (pop && dst_sop)      busy <= 1'b1;
      else if (pop && dst_eop) busy <= 1'b0;
      if (dst_valid && !dst_ready) stall_q <= stall_q + 1'b1;
      else                         stall_q <= '0;
    end
  end

`ifdef PARITY_CHK_EN
  logic [DATA_W-1:0] xor_q;
  logic              perr0_q, perr1_q, in_perr;

  assign in_perr    = in_eop & (xor_q != fifo_data);
  assign parity_err = pop & perr0_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn || soft_reset_out) begin
      xor_q   <= '0;
      perr0_q <= 1'b0;
      perr1_q <= 1'b0;
    end else begin
      if (inflight_q && in_sop)       xor_q <= fifo_data;
      else if (inflight_q && !in_eop) xor_q <= xor_q ^ fifo_data;
      if (pop) perr0_q <= perr1_q;
      if (inflight_q) begin
        if (wr_ent1) perr1_q <= in_perr;
        else         perr0_q <= in_perr;
      end
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_port.sv
// tb/tb_router_out_port.sv - self-checking bench for router_out_port
// Packet-level reference: FIFO and expected-beat queues tagged from the header length.
module tb_router_out_port;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       dst_ready = 1'b0;
  logic       fifo_rd_en, soft_reset_out, dst_valid, dst_sop, dst_eop, parity_err, busy;
  logic [7:0] dst_data;

  router_out_port dut (
    .clock(clock), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .soft_reset_out(soft_reset_out), .dst_ready(dst_ready),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_sop(dst_sop), .dst_eop(dst_eop),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       perr;
  } beat_t;

  beat_t fq[$];
  beat_t eq[$];
  int    hs_cyc[$];
  int    total = 0, bad = 0, cyc = 0;
  int    pkt_pos = 0, stall_run = 0, mode = 0, sr_count = 0;
  int    first_rd = -1, first_vld = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add_pkt(input int len, input int addr, input bit corrupt);
    logic [7:0] hdr, x, b;
    hdr = {len[5:0], addr[1:0]};
    x   = hdr;
    fq.push_back('{hdr, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      x ^= b;
      fq.push_back('{b, 1'b0, 1'b0, 1'b0});
    end
`ifdef PARITY_CHK_EN
    fq.push_back('{corrupt ? (x ^ 8'h5a) : x, 1'b0, 1'b1, corrupt});
`else
    fq.push_back('{corrupt ? (x ^ 8'h5a) : x, 1'b0, 1'b1, 1'b0});
`endif
    fifo_empty = 1'b0;
  endtask

  task automatic cycle();
    bit    rd, hs;
    beat_t e;
    @(negedge clock);
    cyc++;
    rd = fifo_rd_en;
    hs = dst_valid & dst_ready;
    chk("busy", 32'(busy), 32'(pkt_pos != 0));
    chk("soft_reset", 32'(soft_reset_out), 32'(stall_run == 30));
    chk("rd_when_empty", 32'(rd & fifo_empty), 0);
    if (soft_reset_out) chk("rd_in_soft_reset", 32'(rd), 0);
    if (rd && first_rd < 0) first_rd = cyc;
    if (dst_valid && first_vld < 0) first_vld = cyc;
    if (dst_valid) begin
      if (eq.size() == 0) begin
        chk("valid_without_data", 32'(dst_valid), 0);
      end else begin
        e = eq[0];
        chk("data", 32'(dst_data), 32'(e.d));
        chk("sop", 32'(dst_sop), 32'(e.sop));
        chk("eop", 32'(dst_eop), 32'(e.eop));
        chk("parity_err", 32'(parity_err), 32'(hs & e.perr));
        if (hs) begin
          void'(eq.pop_front());
          hs_cyc.push_back(cyc);
          pkt_pos = e.eop ? 0 : pkt_pos + 1;
        end
      end
    end else begin
      chk("parity_err_idle", 32'(parity_err), 0);
    end
    stall_run = (dst_valid && !dst_ready) ? stall_run + 1 : 0;
    if (soft_reset_out) begin
      sr_count++;
      fq.delete();
      eq.delete();
      pkt_pos   = 0;
      stall_run = 0;
    end
    @(posedge clock);
    #1;
    if (rd && fq.size() != 0) begin
      e = fq.pop_front();
      fifo_data = e.d;
      eq.push_back(e);
    end
    fifo_empty = (fq.size() == 0) || (mode == 2 && $urandom_range(0, 3) == 0);
    case (mode)
      0:       dst_ready = 1'b1;
      1:       dst_ready = ~dst_ready;
      2:       dst_ready = 1'($urandom_range(0, 1));
      default: dst_ready = 1'b0;
    endcase
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((fq.size() != 0 || eq.size() != 0) && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(n < maxc), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2;
    chk("rst_valid", 32'(dst_valid), 0);
    chk("rst_data", 32'(dst_data), 0);
    chk("rst_sop", 32'(dst_sop), 0);
    chk("rst_eop", 32'(dst_eop), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_soft", 32'(soft_reset_out), 0);
    chk("rst_perr", 32'(parity_err), 0);
    chk("rst_rd", 32'(fifo_rd_en), 0);
    @(posedge clock);
    #1;
    resetn = 1'b1;

    mode = 0; dst_ready = 1'b1;
    hs_cyc.delete(); first_rd = -1; first_vld = -1;
    add_pkt(4, 1, 1'b0);
    chk("hdr_is_11", 32'(fq[0].d), 32'h11);
    drain(200);
    chk("latency", 32'(first_vld - first_rd), 2);
    chk("pkt1_beats", 32'(hs_cyc.size()), 6);
    chk("pkt1_consec", 32'(hs_cyc[hs_cyc.size()-1] - hs_cyc[0]), 5);

    mode = 1; dst_ready = 1'b1; hs_cyc.delete();
    add_pkt(4, 1, 1'b0);
    drain(200);
    chk("toggle_beats", 32'(hs_cyc.size()), 6);

    mode = 0; dst_ready = 1'b1; hs_cyc.delete();
    add_pkt(0, 2, 1'b0);
    add_pkt(63, 3, 1'b0);
    drain(400);
    chk("b2b_beats", 32'(hs_cyc.size()), 67);
    chk("b2b_consec", 32'(hs_cyc[hs_cyc.size()-1] - hs_cyc[0]), 66);

    add_pkt(7, 0, 1'b0);
    add_pkt(5, 2, 1'b1);
    add_pkt(1, 1, 1'b0);
    drain(200);

    mode = 0; dst_ready = 1'b1; hs_cyc.delete(); sr_count = 0;
    add_pkt(10, 1, 1'b0);
    n = 0;
    while (hs_cyc.size() == 0 && n < 50) begin cycle(); n++; end
    mode = 3; dst_ready = 1'b0;
    n = 0;
    while (sr_count == 0 && n < 100) begin cycle(); n++; end
    chk("soft_reset_seen", 32'(sr_count), 1);
    chk("valid_after_sr", 32'(dst_valid), 0);
    chk("busy_after_sr", 32'(busy), 0);
    mode = 0; dst_ready = 1'b1; hs_cyc.delete();
    add_pkt(3, 2, 1'b0);
    drain(200);
    chk("post_sr_beats", 32'(hs_cyc.size()), 5);

    mode = 2;
    for (int p = 0; p < 12; p++)
      add_pkt($urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    drain(20000);

    mode = 0; dst_ready = 1'b1;
    add_pkt(20, 0, 1'b0);
    repeat (6) cycle();
    resetn = 1'b0;
    #1;
    chk("async_valid", 32'(dst_valid), 0);
    chk("async_sop", 32'(dst_sop), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_data", 32'(dst_data), 0);
    chk("async_rd", 32'(fifo_rd_en), 0);
    @(posedge clock);
    #1;
    chk("async_rd_held", 32'(fifo_rd_en), 0);
    fq.delete(); eq.delete(); pkt_pos = 0; stall_run = 0; fifo_empty = 1'b1;
    resetn = 1'b1;
    hs_cyc.delete();
    add_pkt(2, 3, 1'b0);
    drain(200);
    chk("post_rst_beats", 32'(hs_cyc.size()), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
